traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//   Timed phase generator directly upstream of the traffic-light action decoder.
//   Drives the 2-bit colour code (RED=2'b00, GREEN=2'b01, YELLOW=2'b10) through RED->GREEN->YELLOW->RED.
//   Each phase lasts a parameterised number of enabled clock cycles.
//   Also provides a fault override to RED and a pedestrian request that shortens GREEN.
// PARAMETERS
//   CNT_W           4  width of phase down-counter; must hold max(*_TICKS)-1
//   RED_TICKS       4  enabled cycles spent in RED (>=1)
//   GREEN_TICKS     6  enabled cycles spent in GREEN (>=1)
//   YELLOW_TICKS    2  enabled cycles spent in YELLOW (>=1)
//   MIN_GREEN_TICKS 2  GREEN length when a pedestrian request is honoured (1..GREEN_TICKS)
// PORTS
//   clk         in   1      single clock, rising edge
//   reset_n     in   1      asynchronous, active-low reset
//   enable      in   1      tick qualifier; 0 freezes counter and state
//   fault       in   1      level; forces and holds RED while high
//   ped_req     in   1      pedestrian request pulse (sticky-latched)
//   color       out  2      current phase code, registered; feeds decoder color input
//   ticks_left  out  CNT_W  enabled cycles remaining in phase minus 1, registered
//   phase_start out  1      1-cycle pulse in first cycle of a new phase
// BEHAVIOUR
//   Reset (async assert): color=2'b00, ticks_left=RED_TICKS-1, phase_start=0, ped_pending=0, fault_d=0.
//   FSM states RED, GREEN, YELLOW; 2'b11 is illegal and recovers to RED with ticks_left=RED_TICKS-1.
//   Per-edge priority (highest first):
//     1 fault=1: color<=RED, ticks_left<=RED_TICKS-1.
//       phase_start<=1 only when fault_d=0 (first fault cycle); the enable level is ignored.
//     2 enable=1 and ticks_left==0: advance to the next phase, phase_start<=1.
//       ticks_left<=DUR(next)-1, where DUR = RED_TICKS / GREEN_TICKS / YELLOW_TICKS.
//       Exception on entry to GREEN with ped_pending=1: load MIN_GREEN_TICKS-1.
//     3 enable=1, GREEN, ped_pending=1, ticks_left>MIN_GREEN_TICKS-1: ticks_left<=MIN_GREEN_TICKS-1.
//     4 enable=1: ticks_left<=ticks_left-1.
//     5 otherwise: hold.
//   phase_start is 0 in every cycle not covered by rules 1 and 2.
//   Latency: state change is visible on color one cycle after the deciding edge; no combinational in->out paths.
//   Phase length: exactly DUR enabled cycles; disabled cycles stretch it, no ticks are lost.
//   Fault release: the first cycle with fault=0 starts a full RED phase (RED_TICKS enabled cycles).
//   ped_pending:
//     - set by ped_req=1 in any state, including during fault;
//     - cleared on the transition GREEN->YELLOW;
//     - a ped_req in the same cycle as that transition is not cleared and stays pending for the next GREEN.
//   Simultaneous fault and ticks_left==0: fault wins; the phase does not advance.
//   ticks_left never wraps: it is reloaded at 0 and never decremented below 0.
// CONFIGURATION
//   PED_REQ_EN defined: ped_pending latch and rules 2-exception and 3 active as above.
//   PED_REQ_EN undefined: ped_req port present but ignored; ped_pending is tied 0.
//     GREEN always lasts GREEN_TICKS enabled cycles.
// TESTING (defaults: RED=4, GREEN=6, YELLOW=2, MIN_GREEN=2)
//   1 Release reset, enable=1, fault=0, ped_req=0:
//     color 00 x4 cycles, 01 x6, 10 x2, 00 again.
//     phase_start pulses at cycles 4, 10, 12; ticks_left runs 3..0, 5..0, 1..0.
//   2 In GREEN at ticks_left=3, drop enable for 5 cycles:
//     color stays 01, ticks_left stays 3, phase_start=0; resume gives 01 for 4 more cycles.
//   3 Assert fault in GREEN at ticks_left=4:
//     next cycle color=00, ticks_left=3, phase_start=1; holds for 10 cycles with a single pulse.
//     Release: 4 RED cycles, then GREEN.
//   4 (PED_REQ_EN) pulse ped_req in GREEN at ticks_left=5:
//     next ticks_left=1, YELLOW after 2 more enabled cycles.
//     Without the macro, GREEN runs the full 6 cycles.
//   5 (PED_REQ_EN) pulse ped_req in RED: following GREEN lasts 2 cycles (entry ticks_left=1).
//     Next GREEN after that lasts 6.
//   6 Assert reset_n=0 mid-YELLOW with no clock edge:
//     outputs immediately color=00, ticks_left=3, phase_start=0; pending request lost.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer
// Timed RED -> GREEN -> YELLOW -> RED phase generator that feeds the
// traffic-light action decoder. Each phase lasts a parameterised number of
// enabled clock cycles. A level fault forces and holds RED, and a pedestrian
// request can shorten GREEN.
//
// Optional feature macro: PED_REQ_EN
//   defined   : ped_req is latched into a sticky pending flag that shortens
//               the current or next GREEN to MIN_GREEN_TICKS.
//   undefined : ped_req is ignored and GREEN always lasts GREEN_TICKS.
module traffic_phase_sequencer #(
    parameter int CNT_W           = 4,
    parameter int RED_TICKS       = 4,
    parameter int GREEN_TICKS     = 6,
    parameter int YELLOW_TICKS    = 2,
    parameter int MIN_GREEN_TICKS = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             fault,
    input  logic             ped_req,
    output logic [1:0]       color,
    output logic [CNT_W-1:0] ticks_left,
    output logic             phase_start
);

    // Colour codes double as the state encoding, so color is the state register.
    typedef enum logic [1:0] {
        ST_RED    = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10
    } state_e;

    // Counter reload values: a phase of N enabled cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] RED_LD    = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_LD    = CNT_W'(MIN_GREEN_TICKS - 1);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   ticks_q;
    logic [CNT_W-1:0]   ticks_d;
    logic               start_q;
    logic               start_d;
    logic               fault_q;       // fault as seen on the previous edge
    logic               ped_pending_q;
    logic               ped_pending_d;

    // Request seen this cycle (zero when the pedestrian feature is built out).
    logic               ped_set;
    // Pending request including one arriving this very cycle.
    logic               ped_eff;

    // Decoded "what happens when the current phase expires".
    state_e             next_phase;
    logic [CNT_W-1:0]   next_load;
    logic               state_legal;

`ifdef PED_REQ_EN
    assign ped_set = ped_req;
`else
    // Port kept for a uniform interface; its value is deliberately dropped.
    logic ped_req_unused;
    assign ped_req_unused = ped_req;
    assign ped_set        = 1'b0;
`endif

    assign ped_eff = ped_pending_q | ped_set;

    // Successor phase and its counter reload for the current phase.
    always_comb begin
        next_phase  = ST_RED;
        next_load   = RED_LD;
        state_legal = 1'b1;
        case (state_q)
            ST_RED: begin
                next_phase = ST_GREEN;
                next_load  = ped_eff ? MIN_LD : GREEN_LD;
            end
            ST_GREEN: begin
                next_phase = ST_YELLOW;
                next_load  = YELLOW_LD;
            end
            ST_YELLOW: begin
                next_phase = ST_RED;
                next_load  = RED_LD;
            end
            default: begin
                state_legal = 1'b0;
            end
        endcase
    end

    // Next-state logic: fault override, phase advance, GREEN shortening,
    // countdown, hold -- in that priority order.
    always_comb begin
        state_d       = state_q;
        ticks_d       = ticks_q;
        start_d       = 1'b0;
        ped_pending_d = ped_eff;

        if (fault) begin
            // Enable is ignored; only the first fault cycle marks a new phase.
            state_d = ST_RED;
            ticks_d = RED_LD;
            start_d = ~fault_q;
        end else if (!state_legal) begin
            // Unreachable encoding: fall back to the start of a RED phase.
            state_d = ST_RED;
            ticks_d = RED_LD;
        end else if (enable && (ticks_q == '0)) begin
            state_d = next_phase;
            ticks_d = next_load;
            start_d = 1'b1;
            // Leaving GREEN consumes the pending request; a request arriving
            // on this same edge survives for the next GREEN.
            if (state_q == ST_GREEN) begin
                ped_pending_d = ped_set;
            end
        end else if (enable && (state_q == ST_GREEN) && ped_eff && (ticks_q > MIN_LD)) begin
            ticks_d = MIN_LD;
        end else if (enable) begin
            ticks_d = ticks_q - 1'b1;
        end
    end

    // State, counter and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RED;
            ticks_q       <= RED_LD;
            start_q       <= 1'b0;
            fault_q       <= 1'b0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ticks_q       <= ticks_d;
            start_q       <= start_d;
            fault_q       <= fault;
            ped_pending_q <= ped_pending_d;
        end
    end

    assign color       = state_q;
    assign ticks_left  = ticks_q;
    assign phase_start = start_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer: directed scenarios with
// literal expectations, then randomized stimulus compared every cycle against
// a remaining-cycles model of the phase rules. Honours PED_REQ_EN.
module tb_traffic_phase_sequencer;

    localparam int CNT_W = 4;
    localparam int RED_T = 4;
    localparam int GRN_T = 6;
    localparam int YEL_T = 2;
    localparam int MIN_T = 2;

`ifdef PED_REQ_EN
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             fault;
    logic             ped_req;
    logic [1:0]       color;
    logic [CNT_W-1:0] ticks_left;
    logic             phase_start;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    traffic_phase_sequencer #(
        .CNT_W(CNT_W), .RED_TICKS(RED_T), .GREEN_TICKS(GRN_T),
        .YELLOW_TICKS(YEL_T), .MIN_GREEN_TICKS(MIN_T)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fault(fault),
        .ped_req(ped_req), .color(color), .ticks_left(ticks_left),
        .phase_start(phase_start)
    );

    always #5 clk = ~clk;

    // Model: phase colour index (0 red, 1 green, 2 yellow) and number of
    // enabled cycles still to be spent in it, including the current one.
    typedef struct packed {
        int   col;
        int   rem;
        logic start;
        logic pend;
        logic fprev;
    } mstate_t;

    mstate_t m;

    function automatic int phase_len(input int col, input logic pend);
        if (col == 0) return RED_T;
        if (col == 1) return pend ? MIN_T : GRN_T;
        return YEL_T;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic en,
                                           input logic f, input logic p);
        mstate_t n;
        logic    req;
        logic    pend_now;
        n        = s;
        req      = PED_ON && p;
        pend_now = s.pend || req;
        n.start  = 1'b0;
        n.pend   = pend_now;
        n.fprev  = f;
        if (f) begin
            n.col   = 0;
            n.rem   = RED_T;
            n.start = !s.fprev;
        end else if (en) begin
            if (s.rem == 1) begin
                n.col   = (s.col + 1) % 3;
                n.rem   = phase_len(n.col, pend_now);
                n.start = 1'b1;
                if (s.col == 1) n.pend = req;
            end else if (s.col == 1 && pend_now) begin
                n.rem = (s.rem - 1 < MIN_T) ? s.rem - 1 : MIN_T;
            end else begin
                n.rem = s.rem - 1;
            end
        end
        return n;
    endfunction

    function automatic mstate_t model_reset();
        mstate_t r;
        r.col = 0; r.rem = RED_T; r.start = 1'b0; r.pend = 1'b0; r.fprev = 1'b0;
        return r;
    endfunction

    // Model advances on the same edges as the design.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= model_reset();
        else          m <= model_next(m, enable, fault, ped_req);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model color", int'(color), m.col);
            chk("model ticks_left", int'(ticks_left), m.rem - 1);
            chk("model phase_start", int'(phase_start), int'(m.start));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Bounded wait for a colour (and optionally a ticks_left value).
    task automatic wait_for(input int c, input int t, input string nm);
        int n;
        n = 0;
        while (!(color == c && (t < 0 || ticks_left == t)) && n < 200) begin
            step();
            n++;
        end
        chk(nm, (color == c && (t < 0 || ticks_left == t)) ? 1 : 0, 1);
    endtask

    // Number of consecutive GREEN cycles of the next GREEN phase.
    task automatic measure_green(input string nm, output int len);
        wait_for(1, -1, nm);
        len = 0;
        while (color == 1 && len < 50) begin
            len++;
            step();
        end
    endtask

    int ecol, etk, est, n, pulses, len;

    initial begin
        reset_n = 1'b0; enable = 1'b0; fault = 1'b0; ped_req = 1'b0;
        repeat (3) step();
        chk("reset color", int'(color), 0);
        chk("reset ticks_left", int'(ticks_left), 3);
        chk("reset phase_start", int'(phase_start), 0);
        chk_on = 1'b1;

        // Scenario 1: free-running sequence from reset.
        reset_n = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            ecol = (k < 4) ? 0 : (k < 10) ? 1 : (k < 12) ? 2 : 0;
            etk  = (k < 4) ? 3 - k : (k < 10) ? 9 - k : (k < 12) ? 11 - k : 3;
            est  = (k == 4 || k == 10 || k == 12) ? 1 : 0;
            chk("seq color", int'(color), ecol);
            chk("seq ticks_left", int'(ticks_left), etk);
            chk("seq phase_start", int'(phase_start), est);
        end
        $display("scenario 1 free-run sequence done");

        // Scenario 2: enable dropped in GREEN stretches the phase.
        wait_for(1, 3, "reach green t3");
        enable = 1'b0;
        repeat (5) step();
        chk("stall color", int'(color), 1);
        chk("stall ticks_left", int'(ticks_left), 3);
        enable = 1'b1;
        n = 0;
        while (color == 1 && n < 50) begin n++; step(); end
        chk("stall resume green cycles", n, 4);
        $display("scenario 2 enable stall done");

        // Scenario 3: fault in GREEN, hold, release.
        wait_for(1, 4, "reach green t4");
        fault = 1'b1;
        step();
        chk("fault color", int'(color), 0);
        chk("fault ticks_left", int'(ticks_left), 3);
        chk("fault phase_start", int'(phase_start), 1);
        pulses = 0;
        repeat (9) begin step(); pulses += int'(phase_start); end
        chk("fault extra pulses", pulses, 0);
        fault = 1'b0;
        n = 0;
        while (color != 1 && n < 50) begin step(); n++; end
        chk("fault release red cycles", n, 4);
        $display("scenario 3 fault override done");

        // Scenario 4: pedestrian request early in GREEN.
        wait_for(1, 5, "reach green t5");
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ped shorten ticks_left", int'(ticks_left), PED_ON ? 1 : 4);
        n = 0;
        while (color == 1 && n < 50) begin n++; step(); end
        chk("ped green remaining", n, PED_ON ? 2 : 5);
        $display("scenario 4 ped in green done");

        // Scenario 5: request in RED shortens the following GREEN only.
        wait_for(0, 2, "reach red t2");
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        measure_green("reach green after ped", len);
        chk("ped green length", len, PED_ON ? 2 : 6);
        measure_green("reach next green", len);
        chk("next green length", len, 6);
        $display("scenario 5 ped in red done");

        // Scenario 6: asynchronous reset mid-YELLOW discards a pending request.
        wait_for(2, 1, "reach yellow t1");
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async reset color", int'(color), 0);
        chk("async reset ticks_left", int'(ticks_left), 3);
        chk("async reset phase_start", int'(phase_start), 0);
        step();
        reset_n = 1'b1;
        measure_green("reach green after reset", len);
        chk("green after reset length", len, 6);
        $display("scenario 6 async reset done");

        // Randomized stimulus: enable gaps, fault bursts, sparse requests.
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            enable  = ($urandom_range(0, 3) != 0);
            ped_req = ($urandom_range(0, 19) == 0);
            if (n > 0) begin
                fault = 1'b1;
                n--;
            end else if ($urandom_range(0, 149) == 0) begin
                fault = 1'b1;
                n = $urandom_range(0, 7);
            end else begin
                fault = 1'b0;
            end
            step();
        end
        fault = 1'b0; enable = 1'b1; ped_req = 1'b0;
        step();
        $display("random phase done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
